// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the byte-merge helper for the mem_arbiter slice.
package mem_arb_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RMW_WR,
        RESP
    } state_t;

    // Byte k of the result comes from new_word when be[k] is set, else from old_word.
    function automatic logic [WORD_W-1:0] merge_word(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_arbiter_mem.sv
// Unified single-port word memory: synchronous write, combinational read.
module mem_arbiter_mem
    import mem_arb_pkg::*;
#(
    parameter int unsigned SIZE = 1024,
    parameter int unsigned AW   = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a unified single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin tie resolution; default is data-port priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [WORD_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              busy
);

    localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    state_t            state;
    logic              port_q;
    logic [AW-1:0]     addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] old_q;

    logic              grant;
    logic              accept;
    logic              resp_en;
    logic [WORD_W-1:0] resp_data;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              unused_addr;

`ifdef MEM_ARBITER_RR_EN
    logic last_grant;

    always_comb begin
        grant = PORT_D;
        if (i_valid && d_valid) begin
            grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
        end else if (i_valid) begin
            grant = PORT_I;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant <= PORT_D;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`else
    always_comb begin
        grant = PORT_D;
        if (i_valid && !d_valid) begin
            grant = PORT_I;
        end
    end
`endif

    assign i_ready = (state == IDLE) && (grant == PORT_I);
    assign d_ready = (state == IDLE) && (grant == PORT_D);
    assign accept  = (i_valid && i_ready) || (d_valid && d_ready);
    assign busy    = (state != IDLE);

    // Byte-offset and out-of-range address bits are deliberately ignored.
    assign unused_addr = ^{i_addr[WORD_W-1:AW+2], i_addr[1:0],
                           d_addr[WORD_W-1:AW+2], d_addr[1:0]};

    always_comb begin
        resp_en   = 1'b0;
        resp_data = '0;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        case (state)
            ACCESS: begin
                if (!we_q) begin
                    resp_en   = 1'b1;
                    resp_data = mem_rdata;
                end else if (be_q == '1) begin
                    resp_en = 1'b1;
                    mem_we  = 1'b1;
                end else if (be_q == '0) begin
                    resp_en = 1'b1;
                end
            end
            RMW_WR: begin
                resp_en   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = merge_word(old_q, wdata_q, be_q);
            end
            default: ;
        endcase
        if (RESET) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            port_q   <= PORT_D;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            // Response registers default to idle so RESP presents a single-cycle pulse.
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            if (resp_en) begin
                if (port_q == PORT_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= resp_data;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= resp_data;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        port_q  <= grant;
                        addr_q  <= (grant == PORT_D) ? d_addr[AW+1:2] : i_addr[AW+1:2];
                        we_q    <= (grant == PORT_D) && d_we;
                        be_q    <= d_be;
                        wdata_q <= d_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q && (be_q != '1) && (be_q != '0)) begin
                        old_q <= mem_rdata;
                        state <= RMW_WR;
                    end else begin
                        state <= RESP;
                    end
                end
                RMW_WR:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_arbiter_mem #(
        .SIZE (MEM_SIZE),
        .AW   (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (honours MEM_ARBITER_RR_EN for the tie test).
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        i_valid, i_ready, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_ready, d_we, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MEM_SIZE(64)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_addr   (i_addr),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_wdata  (d_wdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .busy     (busy)
    );

    // Issues one request; lat counts cycles after the accept cycle until rvalid (-1 on timeout).
    task automatic xfer(input bit to_d, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output bit other);
        int t;
        t = 0;
        lat = -1;
        rd = 'x;
        other = 1'b0;
        @(negedge CLK);
        if (to_d) begin
            d_valid = 1'b1; d_addr = addr; d_we = we; d_be = be; d_wdata = wdata;
        end else begin
            i_valid = 1'b1; i_addr = addr;
        end
        #1;
        while (!(to_d ? d_ready : i_ready) && t < 20) begin
            @(negedge CLK);
            #1;
            t++;
        end
        if (t >= 20) begin
            i_valid = 1'b0;
            d_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (to_d ? i_rvalid : d_rvalid) other = 1'b1;
            if (to_d ? d_rvalid : i_rvalid) begin
                lat = k;
                rd  = to_d ? d_rdata : i_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (i_rvalid !== 1'b0) begin errors++; $display("FAIL reset_i_rvalid: got %b expected 0", i_rvalid); end
        checks++;
        if (d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid: got %b expected 0", d_rvalid); end
        checks++;
        if (i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata: got %h expected 00000000", i_rdata); end
        checks++;
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h expected 00000000", d_rdata); end
        checks++;
        if ((i_ready ^ d_ready) !== 1'b1) begin
            errors++; $display("FAIL reset_one_ready: got i_ready=%b d_ready=%b expected exactly one", i_ready, d_ready);
        end
        RESET = 1'b0;
    endtask

    task automatic test_fetch();
        int lat; logic [31:0] rd; bit other;
        xfer(1'b1, 32'h14, 1'b1, 4'hF, 32'hDEADBEEF, lat, rd, other);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL preload_lat: got %0d expected 2", lat); end
        xfer(1'b0, 32'h14, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL fetch_lat: got %0d expected 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data: got %h expected deadbeef", rd); end
        checks++;
        if (other !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid: got %b expected 0", other); end
        @(negedge CLK);
        checks++;
        if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b expected 0", i_rvalid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle: got busy=%b expected 0", busy); end
        xfer(1'b0, 32'h17, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_unaligned: got %h expected deadbeef", rd); end
    endtask

    task automatic test_full_write();
        int lat; logic [31:0] rd; bit other;
        xfer(1'b1, 32'h20, 1'b1, 4'hF, 32'h12345678, lat, rd, other);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d expected 2", lat); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 00000000", rd); end
        checks++;
        if (other !== 1'b0) begin errors++; $display("FAIL wr_i_rvalid: got %b expected 0", other); end
        xfer(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d expected 2", lat); end
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", rd); end
    endtask

    task automatic test_partial_write();
        int lat; logic [31:0] rd; bit other;
        xfer(1'b1, 32'h20, 1'b1, 4'hF, 32'hAABBCCDD, lat, rd, other);
        xfer(1'b1, 32'h20, 1'b1, 4'b0010, 32'h0000EE00, lat, rd, other);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL pw_lat: got %0d expected 3", lat); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL pw_rdata: got %h expected 00000000", rd); end
        xfer(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (rd !== 32'hAABBEEDD) begin errors++; $display("FAIL pw_readback: got %h expected aabbeedd", rd); end
        xfer(1'b1, 32'h20, 1'b1, 4'b1001, 32'h11223344, lat, rd, other);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL pw2_lat: got %0d expected 3", lat); end
        xfer(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (rd !== 32'h11BBEE44) begin errors++; $display("FAIL pw2_readback: got %h expected 11bbee44", rd); end
    endtask

    task automatic test_zero_be();
        int lat; logic [31:0] rd; bit other;
        xfer(1'b1, 32'h0C, 1'b1, 4'hF, 32'h11111111, lat, rd, other);
        xfer(1'b1, 32'h0C, 1'b1, 4'h0, 32'hFFFFFFFF, lat, rd, other);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL zbe_lat: got %0d expected 2", lat); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL zbe_rdata: got %h expected 00000000", rd); end
        xfer(1'b1, 32'h0C, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (rd !== 32'h11111111) begin errors++; $display("FAIL zbe_readback: got %h expected 11111111", rd); end
    endtask

    task automatic test_tie();
        logic [3:0] grants;   // bit n = 1 when transaction n went to the data port
        logic [3:0] expected;
        int n;
        bit both_ready, ready_busy;
        n = 0;
        grants = '0;
        both_ready = 1'b0;
        ready_busy = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        expected = 4'b1010;   // I,D,I,D
`else
        expected = 4'b1111;   // D,D,D,D
`endif
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        i_valid = 1'b1; i_addr = 32'h14;
        d_valid = 1'b1; d_addr = 32'h20; d_we = 1'b0; d_be = 4'h0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (i_ready && d_ready) both_ready = 1'b1;
            if (busy && (i_ready || d_ready)) ready_busy = 1'b1;
            if (d_ready) begin grants[n] = 1'b1; n++; end
            else if (i_ready) begin grants[n] = 1'b0; n++; end
            @(negedge CLK);
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL tie_count: got %0d grants expected 4", n); end
        checks++;
        if (grants !== expected) begin errors++; $display("FAIL tie_order: got %b expected %b", grants, expected); end
        checks++;
        if (both_ready !== 1'b0) begin errors++; $display("FAIL tie_both_ready: got %b expected 0", both_ready); end
        checks++;
        if (ready_busy !== 1'b0) begin errors++; $display("FAIL tie_ready_busy: got %b expected 0", ready_busy); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; bit other;
        bit seen;
        seen = 1'b0;
        xfer(1'b1, 32'h28, 1'b1, 4'hF, 32'h01020304, lat, rd, other);
        @(negedge CLK);
        d_valid = 1'b1; d_addr = 32'h28; d_we = 1'b1; d_be = 4'b0100; d_wdata = 32'h00FF0000;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", d_ready); end
        @(posedge CLK);
        #1;
        d_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_after: got %b expected 0", busy); end
        checks++;
        if (d_rvalid !== 1'b0) begin errors++; $display("FAIL rm_d_rvalid: got %b expected 0", d_rvalid); end
        checks++;
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL rm_d_rdata: got %h expected 00000000", d_rdata); end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (d_rvalid || i_rvalid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rm_late_resp: got %b expected 0", seen); end
        xfer(1'b1, 32'h28, 1'b0, 4'h0, 32'h0, lat, rd, other);
        checks++;
        if (rd !== 32'h01020304) begin errors++; $display("FAIL rm_word: got %h expected 01020304", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;
        test_reset();
        test_fetch();
        test_full_write();
        test_partial_write();
        test_zero_be();
        test_tie();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
